ibex_rf_wb_arbiter: RTL and testbench

// - Writeback stage directly upstream of the register file. Owns the single RF write port
//   (rf_we_o/rf_waddr_o/rf_wdata_o).
// - Merges two result sources:
//   - LSU load data: cannot stall, has priority.
//   - EX/ALU results: valid/ready handshake, parked in a small in-order FIFO while the port is busy.
// - Optionally forwards pending (not yet written) results to the ID-stage operand reads.

---
 rtl/ibex_rf_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_wb_arbiter.sv
// Writeback arbiter owning the single register-file write port (LSU data first, then queued EX results).
// Define IBEX_WB_FWD_EN to build operand forwarding from results that are not yet written.
module ibex_rf_wb_arbiter #(
  parameter int DataWidth = 32,
  parameter int Depth     = 2,
  parameter bit RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_hit_a_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
  output logic [2:0]           count_o,
  output logic                 err_o
);

  // Shift-register FIFO: entry 0 is the head, entry count-1 the youngest.
  logic [4:0]           ent_addr   [Depth];
  logic [DataWidth-1:0] ent_data   [Depth];
  logic [Depth-1:0]     ent_vld;
  logic [4:0]           ent_addr_n [Depth];
  logic [DataWidth-1:0] ent_data_n [Depth];
  logic [Depth-1:0]     ent_vld_n;
  logic [2:0]           count, count_n;
  int                   wr_idx;

  logic lsu_illegal, ex_illegal, lsu_sel, head_sel, ex_acc, ex_keep, direct_sel, push, pop;

  assign count_o     = count;
  assign ex_ready_o  = !rst_i && (count < 3'(Depth));
  assign lsu_illegal = RV32E && lsu_valid_i && lsu_waddr_i[4];
  assign ex_illegal  = RV32E && ex_waddr_i[4];
  assign lsu_sel     = !rst_i && lsu_valid_i && (lsu_waddr_i != 5'd0) && !lsu_illegal;
  assign head_sel    = !rst_i && !lsu_sel && (count != 3'd0);
  assign ex_acc      = ex_valid_i && ex_ready_o;
  assign ex_keep     = ex_acc && (ex_waddr_i != 5'd0) && !ex_illegal;
  assign direct_sel  = ex_keep && !lsu_sel && (count == 3'd0);
  assign push        = ex_keep && !direct_sel;
  assign pop         = head_sel;
  assign err_o       = !rst_i && (lsu_illegal || (ex_acc && ex_illegal));
  assign count_n     = count + {2'b00, push} - {2'b00, pop};

  always_comb begin
    ent_vld_n  = ent_vld;
    ent_addr_n = ent_addr;
    ent_data_n = ent_data;
    wr_idx     = int'(count) - int'(pop);
    // The LSU write is younger than every queued entry, so older same-register entries die.
    if (lsu_sel) begin
      for (int i = 0; i < Depth; i++) begin
        if (ent_addr[i] == lsu_waddr_i) ent_vld_n[i] = 1'b0;
      end
    end
    if (pop) begin
      for (int i = 0; i < Depth - 1; i++) begin
        ent_vld_n[i]  = ent_vld_n[i+1];
        ent_addr_n[i] = ent_addr_n[i+1];
        ent_data_n[i] = ent_data_n[i+1];
      end
      ent_vld_n[Depth-1] = 1'b0;
    end
    for (int i = 0; i < Depth; i++) begin
      if (push && (i == wr_idx)) begin
        ent_vld_n[i]  = 1'b1;
        ent_addr_n[i] = ex_waddr_i;
        ent_data_n[i] = ex_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= 3'd0;
      ent_vld <= '0;
      for (int i = 0; i < Depth; i++) begin
        ent_addr[i] <= 5'd0;
        ent_data[i] <= '0;
      end
    end else begin
      count    <= count_n;
      ent_vld  <= ent_vld_n;
      ent_addr <= ent_addr_n;
      ent_data <= ent_data_n;
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = '0;
    if (lsu_sel) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end else if (head_sel) begin
      rf_we_o    = ent_vld[0];
      rf_waddr_o = ent_addr[0];
      rf_wdata_o = ent_data[0];
    end else if (direct_sel) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
    end
  end

`ifdef IBEX_WB_FWD_EN
  // Ascending scan lets younger entries override older ones; the LSU input overrides all.
  always_comb begin
    fwd_hit_a_o  = 1'b0;
    fwd_data_a_o = '0;
    fwd_hit_b_o  = 1'b0;
    fwd_data_b_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (ent_vld[i] && (ent_addr[i] == raddr_a_i) && (raddr_a_i != 5'd0)) begin
        fwd_hit_a_o  = 1'b1;
        fwd_data_a_o = ent_data[i];
      end
      if (ent_vld[i] && (ent_addr[i] == raddr_b_i) && (raddr_b_i != 5'd0)) begin
        fwd_hit_b_o  = 1'b1;
        fwd_data_b_o = ent_data[i];
      end
    end
    if (lsu_sel && (lsu_waddr_i == raddr_a_i) && (raddr_a_i != 5'd0)) begin
      fwd_hit_a_o  = 1'b1;
      fwd_data_a_o = lsu_wdata_i;
    end
    if (lsu_sel && (lsu_waddr_i == raddr_b_i) && (raddr_b_i != 5'd0)) begin
      fwd_hit_b_o  = 1'b1;
      fwd_data_b_o = lsu_wdata_i;
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr_a_i, raddr_b_i};
  assign fwd_hit_a_o  = 1'b0;
  assign fwd_data_a_o = '0;
  assign fwd_hit_b_o  = 1'b0;
  assign fwd_data_b_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter: expected RF writes are queued when driven and
// popped by a write monitor; a second RV32E instance covers the illegal-address drop.
module tb_ibex_rf_wb_arbiter;
  localparam int DW = 32;
`ifdef IBEX_WB_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk, rst;
  logic ex_valid, lsu_valid;
  logic [4:0] ex_waddr, lsu_waddr, raddr_a, raddr_b;
  logic [DW-1:0] ex_wdata, lsu_wdata;

  logic ex_ready, rf_we, fwd_hit_a, fwd_hit_b, err;
  logic [4:0] rf_waddr;
  logic [DW-1:0] rf_wdata, fwd_data_a, fwd_data_b;
  logic [2:0] count;

  logic ex_ready_e, rf_we_e, fwd_hit_a_e, fwd_hit_b_e, err_e;
  logic [4:0] rf_waddr_e;
  logic [DW-1:0] rf_wdata_e, fwd_data_a_e, fwd_data_b_e;
  logic [2:0] count_e;

  int tests_run = 0;
  int fails = 0;
  wr_t exp_q[$];

  ibex_rf_wb_arbiter #(.DataWidth(DW), .Depth(2), .RV32E(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .fwd_hit_a_o(fwd_hit_a), .fwd_data_a_o(fwd_data_a),
    .fwd_hit_b_o(fwd_hit_b), .fwd_data_b_o(fwd_data_b),
    .count_o(count), .err_o(err)
  );

  ibex_rf_wb_arbiter #(.DataWidth(DW), .Depth(2), .RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready_e), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we_e), .rf_waddr_o(rf_waddr_e), .rf_wdata_o(rf_wdata_e),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .fwd_hit_a_o(fwd_hit_a_e), .fwd_data_a_o(fwd_data_a_e),
    .fwd_hit_b_o(fwd_hit_b_e), .fwd_data_b_o(fwd_data_b_e),
    .count_o(count_e), .err_o(err_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every RF write of the main instance must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: got x%0d=%0h, none expected", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== {e.a, e.d}) begin
          fails++;
          $display("[TB] FAIL rf_write: got x%0d=%0h, exp x%0d=%0h", rf_waddr, rf_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic applyStimulus(input logic ev, input logic [4:0] ea, input logic [DW-1:0] ed,
                               input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
    @(posedge clk);
    #1;
    ex_valid = ev; ex_waddr = ea; ex_wdata = ed;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    raddr_a = 5'd0; raddr_b = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ex_valid = 0; ex_waddr = 0; ex_wdata = 0;
    lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
    raddr_a = 0; raddr_b = 0;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({count, ex_ready, rf_we, err} !== 6'b000_0_0_0) begin
      fails++;
      $display("[TB] FAIL reset_state: got cnt=%0d rdy=%b we=%b err=%b, exp 0/0/0/0", count, ex_ready, rf_we, err);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    tests_run++;
    if (ex_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_ready: got %b exp 1", ex_ready);
    end
  endtask

  task automatic test_direct();
    applyStimulus(1, 5'd5, 32'hA5, 0, 5'd0, 0);
    exp_q.push_back({5'd5, 32'hA5});
    @(negedge clk);
    tests_run++;
    if ({rf_we, count} !== {1'b1, 3'd0}) begin
      fails++;
      $display("[TB] FAIL direct_path: got we=%b cnt=%0d, exp we=1 cnt=0", rf_we, count);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL direct_nopush: got cnt=%0d exp 0", count);
    end
  endtask

  task automatic test_contention();
    applyStimulus(1, 5'd3, 32'h22, 1, 5'd7, 32'h11);
    exp_q.push_back({5'd7, 32'h11});
    exp_q.push_back({5'd3, 32'h22});
    @(negedge clk);
    tests_run++;
    if (ex_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL contention_ready: got %b exp 1", ex_ready);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd1) begin
      fails++;
      $display("[TB] FAIL contention_cnt1: got %0d exp 1", count);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL contention_cnt0: got %0d exp 0", count);
    end
  endtask

  task automatic test_full();
    applyStimulus(1, 5'd9, 32'h200, 1, 5'd8, 32'h100);
    exp_q.push_back({5'd8, 32'h100});
    @(negedge clk);
    applyStimulus(1, 5'd11, 32'h201, 1, 5'd10, 32'h101);
    exp_q.push_back({5'd10, 32'h101});
    @(negedge clk);
    applyStimulus(1, 5'd13, 32'h202, 1, 5'd12, 32'h102);
    raddr_a = 5'd9; raddr_b = 5'd11;
    exp_q.push_back({5'd12, 32'h102});
    @(negedge clk);
    tests_run++;
    if ({count, ex_ready} !== {3'd2, 1'b0}) begin
      fails++;
      $display("[TB] FAIL full_ready: got cnt=%0d rdy=%b, exp cnt=2 rdy=0", count, ex_ready);
    end
    tests_run++;
    if ({fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b} !==
        {Fwd, Fwd ? 32'h200 : 32'h0, Fwd, Fwd ? 32'h201 : 32'h0}) begin
      fails++;
      $display("[TB] FAIL fwd_fifo: got a=%b/%0h b=%b/%0h, exp fwd_en=%b a=200 b=201", fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b, Fwd);
    end
    applyStimulus(1, 5'd13, 32'h202, 0, 5'd0, 0);
    exp_q.push_back({5'd9, 32'h200});
    @(negedge clk);
    tests_run++;
    if ({count, ex_ready} !== {3'd2, 1'b0}) begin
      fails++;
      $display("[TB] FAIL full_hold: got cnt=%0d rdy=%b, exp cnt=2 rdy=0", count, ex_ready);
    end
    applyStimulus(1, 5'd13, 32'h202, 0, 5'd0, 0);
    exp_q.push_back({5'd11, 32'h201});
    @(negedge clk);
    tests_run++;
    if ({count, ex_ready} !== {3'd1, 1'b1}) begin
      fails++;
      $display("[TB] FAIL full_pushpop: got cnt=%0d rdy=%b, exp cnt=1 rdy=1", count, ex_ready);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    exp_q.push_back({5'd13, 32'h202});
    @(negedge clk);
    tests_run++;
    if (count !== 3'd1) begin
      fails++;
      $display("[TB] FAIL full_cnt_held: got %0d exp 1", count);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL full_drained: got %0d exp 0", count);
    end
  endtask

  task automatic test_squash();
    applyStimulus(1, 5'd4, 32'h1, 1, 5'd6, 32'h50);
    raddr_b = 5'd6;
    exp_q.push_back({5'd6, 32'h50});
    @(negedge clk);
    tests_run++;
    if ({fwd_hit_b, fwd_data_b} !== {Fwd, Fwd ? 32'h50 : 32'h0}) begin
      fails++;
      $display("[TB] FAIL fwd_lsu: got %b/%0h, exp fwd_en=%b data 50", fwd_hit_b, fwd_data_b, Fwd);
    end
    applyStimulus(0, 5'd0, 0, 1, 5'd4, 32'h9);
    raddr_a = 5'd4;
    exp_q.push_back({5'd4, 32'h9});
    @(negedge clk);
    tests_run++;
    if ({fwd_hit_a, fwd_data_a} !== {Fwd, Fwd ? 32'h9 : 32'h0}) begin
      fails++;
      $display("[TB] FAIL fwd_lsu_priority: got %b/%0h, exp fwd_en=%b data 9", fwd_hit_a, fwd_data_a, Fwd);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    raddr_a = 5'd4;
    @(negedge clk);
    tests_run++;
    if ({rf_we, count, fwd_hit_a} !== {1'b0, 3'd1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL squash_drain: got we=%b cnt=%0d hit=%b, exp 0/1/0", rf_we, count, fwd_hit_a);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL squash_empty: got %0d exp 0", count);
    end
  endtask

  task automatic test_fwd_order();
    applyStimulus(1, 5'd21, 32'hA, 1, 5'd20, 32'h1);
    exp_q.push_back({5'd20, 32'h1});
    @(negedge clk);
    applyStimulus(1, 5'd21, 32'hB, 1, 5'd22, 32'h2);
    exp_q.push_back({5'd22, 32'h2});
    @(negedge clk);
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    raddr_a = 5'd21;
    exp_q.push_back({5'd21, 32'hA});
    @(negedge clk);
    tests_run++;
    if ({fwd_hit_a, fwd_data_a} !== {Fwd, Fwd ? 32'hB : 32'h0}) begin
      fails++;
      $display("[TB] FAIL fwd_youngest: got %b/%0h, exp fwd_en=%b data b", fwd_hit_a, fwd_data_a, Fwd);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    exp_q.push_back({5'd21, 32'hB});
    @(negedge clk);
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL fwd_order_empty: got %0d exp 0", count);
    end
  endtask

  task automatic test_x0();
    applyStimulus(1, 5'd0, 32'h77, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if ({ex_ready, rf_we} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL ex_x0: got rdy=%b we=%b, exp rdy=1 we=0", ex_ready, rf_we);
    end
    applyStimulus(0, 5'd0, 0, 1, 5'd0, 32'h55);
    @(negedge clk);
    tests_run++;
    if ({rf_we, count} !== {1'b0, 3'd0}) begin
      fails++;
      $display("[TB] FAIL lsu_x0: got we=%b cnt=%0d, exp we=0 cnt=0", rf_we, count);
    end
    applyStimulus(1, 5'd3, 32'h33, 1, 5'd0, 32'h66);
    exp_q.push_back({5'd3, 32'h33});
    @(negedge clk);
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL x0_no_push: got %0d exp 0", count);
    end
  endtask

  task automatic test_rv32e();
    @(negedge clk);
    tests_run++;
    if (count_e !== 3'd0) begin
      fails++;
      $display("[TB] FAIL rv32e_idle: got cnt=%0d exp 0", count_e);
    end
    applyStimulus(1, 5'd17, 32'h33, 0, 5'd0, 0);
    exp_q.push_back({5'd17, 32'h33});
    @(negedge clk);
    tests_run++;
    if ({err_e, rf_we_e, ex_ready_e, err} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL rv32e_ex: got err=%b we=%b rdy=%b main_err=%b, exp 1/0/1/0", err_e, rf_we_e, ex_ready_e, err);
    end
    applyStimulus(0, 5'd0, 0, 1, 5'd18, 32'h44);
    exp_q.push_back({5'd18, 32'h44});
    @(negedge clk);
    tests_run++;
    if ({err_e, rf_we_e} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL rv32e_lsu: got err=%b we=%b, exp 1/0", err_e, rf_we_e);
    end
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    tests_run++;
    if ({err_e, count_e} !== {1'b0, 3'd0}) begin
      fails++;
      $display("[TB] FAIL rv32e_after: got err=%b cnt=%0d, exp 0/0", err_e, count_e);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 5'd2, 32'h2, 1, 5'd1, 32'h1);
    exp_q.push_back({5'd1, 32'h1});
    @(negedge clk);
    applyStimulus(1, 5'd5, 32'h5, 1, 5'd3, 32'h3);
    exp_q.push_back({5'd3, 32'h3});
    @(negedge clk);
    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
    tests_run++;
    if (count !== 3'd2) begin
      fails++;
      $display("[TB] FAIL reset_mid_fill: got %0d exp 2", count);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({count, ex_ready, rf_we} !== {3'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_async: got cnt=%0d rdy=%b we=%b, exp 0/0/0", count, ex_ready, rf_we);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 5'd0, 0, 0, 5'd0, 0);
      @(negedge clk);
    end
    tests_run++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL reset_release: got %0d exp 0", count);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_contention();
    test_full();
    test_squash();
    test_fwd_order();
    test_x0();
    test_rv32e();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL missing_writes: got %0d outstanding, exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
